// File: rtl/sma_window.sv
// Running-sum moving average over the last 2^LOG2_DEPTH signed samples.
// One-cycle latency; unwritten slots since reset/clr count as zero.
module sma_window #(
  parameter int DATA_W     = 16,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                in_valid,
  input  logic signed [DATA_W-1:0]            x,
  output logic                                out_valid,
  output logic signed [DATA_W-1:0]            y,
  output logic signed [DATA_W+LOG2_DEPTH-1:0] y_sum,
  output logic                                full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ACC_W = DATA_W + LOG2_DEPTH;
  localparam int RI    = (ROUND != 0) ? (1 << (LOG2_DEPTH - 1)) : 0;

  localparam logic [LOG2_DEPTH:0] CMAX = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [ACC_W:0]      RV   = (ACC_W + 1)'(RI);

  logic signed [DATA_W-1:0] hist [DEPTH];
  logic [LOG2_DEPTH-1:0]    wr_ptr;
  logic [LOG2_DEPTH:0]      cnt;
  logic [LOG2_DEPTH:0]      cnt_n;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_n;
  logic signed [DATA_W-1:0] oldest;
  logic signed [ACC_W:0]    rs;
  logic signed [ACC_W:0]    sh;
  logic signed [DATA_W-1:0] avg;

  always_comb begin
    oldest = (cnt == CMAX) ? hist[wr_ptr] : '0;
    acc_n  = acc
           + {{LOG2_DEPTH{x[DATA_W-1]}}, x}
           - {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};
    rs     = {acc_n[ACC_W-1], acc_n} + RV;
    sh     = rs >>> LOG2_DEPTH;
    avg    = sh[DATA_W-1:0];
    // Rounding can only push a positive result past the top of range
    if (!sh[ACC_W] && (|sh[ACC_W-1:DATA_W-1]))
      avg = {1'b0, {(DATA_W-1){1'b1}}};
    cnt_n  = (cnt == CMAX) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      wr_ptr    <= '0;
      y         <= '0;
      y_sum     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      wr_ptr    <= '0;
      y         <= '0;
      y_sum     <= '0;
      out_valid <= 1'b0;
      full      <= 1'b0;
    end else if (in_valid) begin
      acc       <= acc_n;
      cnt       <= cnt_n;
      wr_ptr    <= wr_ptr + 1'b1;
      y         <= avg;
      y_sum     <= acc_n;
      out_valid <= 1'b1;
      full      <= (cnt_n == CMAX);
    end else begin
      out_valid <= 1'b0;
    end
  end

  // History is never cleared; cnt masks stale slots
  always_ff @(posedge clk) begin
    if (in_valid && !clr)
      hist[wr_ptr] <= x;
  end

endmodule

// File: tb/tb_sma_window.sv
// Directed plus random checks of sma_window (truncate and round builds)
// against a queue-based window model.
module tb_sma_window;

  logic               clk;
  logic               rst;
  logic               clr;
  logic               in_valid;
  logic signed [15:0] x;

  logic               v0, v1, f0, f1;
  logic signed [15:0] y0, y1;
  logic signed [17:0] s0, s1;

  int n_chk;
  int n_fail;

  int win[$];
  int e_sum, e_y0, e_y1;
  bit e_v, e_full;

  sma_window #(.DATA_W(16), .LOG2_DEPTH(2), .ROUND(0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
    .out_valid(v0), .y(y0), .y_sum(s0), .full(f0)
  );

  sma_window #(.DATA_W(16), .LOG2_DEPTH(2), .ROUND(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .x(x),
    .out_valid(v1), .y(y1), .y_sum(s1), .full(f1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    win.delete();
    e_sum  = 0;
    e_y0   = 0;
    e_y1   = 0;
    e_v    = 0;
    e_full = 0;
  endtask

  task automatic model_step(input bit v, input int xv, input bit c);
    if (c) begin
      model_clear();
    end else if (v) begin
      win.push_back(xv);
      if (win.size() > 4) void'(win.pop_front());
      e_sum = 0;
      foreach (win[i]) e_sum += win[i];
      e_y0 = fdiv(e_sum, 4);
      e_y1 = fdiv(e_sum + 2, 4);
      if (e_y1 > 32767) e_y1 = 32767;
      e_v    = 1;
      e_full = (win.size() == 4);
    end else begin
      e_v = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".v0"},   longint'(v0), longint'(e_v));
    chk({tag, ".v1"},   longint'(v1), longint'(e_v));
    chk({tag, ".sum0"}, longint'(s0), longint'(e_sum));
    chk({tag, ".sum1"}, longint'(s1), longint'(e_sum));
    chk({tag, ".y0"},   longint'(y0), longint'(e_y0));
    chk({tag, ".y1"},   longint'(y1), longint'(e_y1));
    chk({tag, ".f0"},   longint'(f0), longint'(e_full));
    chk({tag, ".f1"},   longint'(f1), longint'(e_full));
  endtask

  task automatic step(input string tag, input bit v, input int xv,
                      input bit c);
    in_valid = v;
    x        = xv[15:0];
    clr      = c;
    @(posedge clk);
    #1;
    model_step(v, xv, c);
    check_all(tag);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    int xv;
    bit v, c;
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    model_clear();

    #2 rst = 1'b0;
    #1 check_all("reset_async");
    @(posedge clk);
    #1 check_all("reset_held");
    #4 rst = 1'b1;

    // fill and slide
    step("fill1", 1, 4, 0);
    step("fill2", 1, 8, 0);
    step("fill3", 1, 12, 0);
    step("fill4", 1, 16, 0);
    step("fill5", 1, 20, 0);
    step("fill_idle", 0, 0, 0);

    // negative rounding
    step("neg_clr", 0, 0, 1);
    step("neg1", 1, -1, 0);
    step("neg2", 1, -2, 0);

    // extremes
    step("ext_clr", 0, 0, 1);
    for (int i = 0; i < 4; i++) step("ext_max", 1, 32767, 0);
    for (int i = 0; i < 4; i++) step("ext_min", 1, -32768, 0);

    // gapped valid
    step("gap_clr", 0, 0, 1);
    step("gap_a", 1, 8, 0);
    for (int i = 0; i < 3; i++) step("gap_idle", 0, 5, 0);
    step("gap_b", 1, 8, 0);

    // clear drops simultaneous sample
    step("clr_clr", 0, 0, 1);
    for (int i = 0; i < 4; i++) step("clr_fill", 1, 10, 0);
    step("clr_drop", 1, 100, 1);
    step("clr_next", 1, 4, 0);

    // async reset mid-stream
    step("ar1", 1, 7, 0);
    step("ar2", 1, -9, 0);
    step("ar3", 1, 30, 0);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_all("ar_async");
    #1 rst = 1'b1;
    step("ar_post", 1, 4, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      xv = int'($urandom_range(0, 65535)) - 32768;
      case ($urandom_range(0, 9))
        0:       xv = 32767;
        1:       xv = -32768;
        default: ;
      endcase
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      step("rand", v, xv, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
